// File: rtl/match_reporter.sv
// Counts rising edges of w per WINDOW-cycle window and queues one record per window in a 2-entry FIFO.
// Optional threshold irq is built only when MATCH_REPORTER_IRQ_EN is defined.
module match_reporter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 4,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w,
    input  logic             clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic [7:0]       drop_cnt,
    output logic             irq
);
    localparam int IDX_W = $clog2(WINDOW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Saturating increment; the MSB of the result flags an attempted overflow.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic inc);
        logic [CNT_W:0] res;
        if (inc && (a == CNT_MAX)) begin
            res = {1'b1, CNT_MAX};
        end else begin
            res = {1'b0, a + CNT_W'(inc)};
        end
        return res;
    endfunction

    logic             w_d_r;
    logic [IDX_W-1:0] widx_r;
    logic [CNT_W-1:0] acc_r;
    logic             sat_r;
    logic [CNT_W-1:0] tail_count_r;
    logic             tail_sat_r;
    logic [1:0]       fill_r;

    logic             match_s;
    logic [CNT_W:0]   add_s;
    logic [CNT_W-1:0] rec_count_s;
    logic             rec_sat_s;
    logic             last_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic [1:0]       fill_nxt_s;
    logic [CNT_W-1:0] head_count_nxt_s;
    logic             head_sat_nxt_s;
    logic [CNT_W-1:0] tail_count_nxt_s;
    logic             tail_sat_nxt_s;

    // Record for the current cycle includes this cycle's match, so boundary edges land in the closing window.
    always_comb begin
        match_s     = w & ~w_d_r;
        add_s       = sat_add(acc_r, match_s);
        rec_count_s = add_s[CNT_W-1:0];
        rec_sat_s   = sat_r | add_s[CNT_W];
        last_s      = (widx_r == LAST_IDX);
        push_s      = last_s & ~clr;
        pop_s       = out_valid & out_ready;
    end

    // Window index, accumulator and sticky saturation; clr outranks the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_d_r  <= 1'b0;
            widx_r <= '0;
            acc_r  <= '0;
            sat_r  <= 1'b0;
        end else begin
            w_d_r <= w;
            if (clr || last_s) begin
                widx_r <= '0;
                acc_r  <= '0;
                sat_r  <= 1'b0;
            end else begin
                widx_r <= widx_r + IDX_W'(1);
                acc_r  <= add_s[CNT_W-1:0];
                sat_r  <= rec_sat_s;
            end
        end
    end

    // FIFO next state; head lives directly in the output registers. Pop is impossible while empty.
    always_comb begin
        fill_nxt_s       = fill_r;
        head_count_nxt_s = out_count;
        head_sat_nxt_s   = out_sat;
        tail_count_nxt_s = tail_count_r;
        tail_sat_nxt_s   = tail_sat_r;
        drop_s           = 1'b0;
        case ({fill_r, push_s, pop_s})
            4'b0010: begin
                head_count_nxt_s = rec_count_s;
                head_sat_nxt_s   = rec_sat_s;
                fill_nxt_s       = 2'd1;
            end
            4'b0101: fill_nxt_s = 2'd0;
            4'b0110: begin
                tail_count_nxt_s = rec_count_s;
                tail_sat_nxt_s   = rec_sat_s;
                fill_nxt_s       = 2'd2;
            end
            4'b0111: begin
                head_count_nxt_s = rec_count_s;
                head_sat_nxt_s   = rec_sat_s;
            end
            4'b1001: begin
                head_count_nxt_s = tail_count_r;
                head_sat_nxt_s   = tail_sat_r;
                fill_nxt_s       = 2'd1;
            end
            4'b1010: drop_s = 1'b1;
            4'b1011: begin
                head_count_nxt_s = tail_count_r;
                head_sat_nxt_s   = tail_sat_r;
                tail_count_nxt_s = rec_count_s;
                tail_sat_nxt_s   = rec_sat_s;
            end
            default: fill_nxt_s = fill_r;
        endcase
    end

    // FIFO storage, registered handshake outputs and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_r       <= 2'd0;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_sat      <= 1'b0;
            tail_count_r <= '0;
            tail_sat_r   <= 1'b0;
            drop_cnt     <= 8'd0;
        end else begin
            fill_r       <= fill_nxt_s;
            out_valid    <= (fill_nxt_s != 2'd0);
            out_count    <= head_count_nxt_s;
            out_sat      <= head_sat_nxt_s;
            tail_count_r <= tail_count_nxt_s;
            tail_sat_r   <= tail_sat_nxt_s;
            if (drop_s && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end

`ifdef MATCH_REPORTER_IRQ_EN
    localparam int unsigned THRESH_U = THRESH;

    // One-cycle pulse aligned with the push attempt, raised even if the record is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= push_s && (32'(rec_count_s) >= THRESH_U);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_match_reporter.sv
// Directed bench for match_reporter: table of per-window patterns plus hand-written multi-cycle sequences.
module tb_match_reporter;
    logic       clk = 1'b0;
    logic       rst;
    logic       w;
    logic       clr;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_count;
    logic       out_sat;
    logic [7:0] drop_cnt;
    logic       irq;

    logic       w40;
    logic       clr40;
    logic       out_ready40;
    logic       out_valid40;
    logic [3:0] out_count40;
    logic       out_sat40;
    logic [7:0] drop_cnt40;
    logic       irq40;

    int total = 0;
    int bad   = 0;

`ifdef MATCH_REPORTER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] wpat;
        logic [3:0]  exp_count;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [8];

    match_reporter u_dut (
        .clk(clk), .rst(rst), .w(w), .clr(clr), .out_ready(out_ready),
        .out_valid(out_valid), .out_count(out_count), .out_sat(out_sat),
        .drop_cnt(drop_cnt), .irq(irq)
    );

    match_reporter #(.WINDOW(40)) u_dut40 (
        .clk(clk), .rst(rst), .w(w40), .clr(clr40), .out_ready(out_ready40),
        .out_valid(out_valid40), .out_count(out_count40), .out_sat(out_sat40),
        .drop_cnt(drop_cnt40), .irq(irq40)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at the negedge where cycle 0 (widx 0) begins.
    task automatic do_reset();
        rst = 1'b1;
        w = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        w40 = 1'b0;
        clr40 = 1'b0;
        out_ready40 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_pat(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            w = pat[i];
            @(negedge clk);
        end
        w = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h0092, 4'd3, 1'b0};
        vecs[1] = '{16'h007C, 4'd1, 1'b0};
        vecs[2] = '{16'h8000, 4'd1, 1'b0};
        vecs[3] = '{16'h0000, 4'd0, 1'b0};
        vecs[4] = '{16'h5555, 4'd8, 1'b0};
        vecs[5] = '{16'hFFFF, 4'd1, 1'b0};
        vecs[6] = '{16'hFFFE, 4'd1, 1'b0};
        vecs[7] = '{16'h0001, 4'd0, 1'b0};

        rst = 1'b1;
        w = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        w40 = 1'b0;
        clr40 = 1'b0;
        out_ready40 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_sat",   32'(out_sat),   32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        chk("rst_irq",   32'(irq),       32'd0);

        // Table: one window per vector, record checked in the first two cycles of the next window.
        do_reset();
        for (int v = 0; v <= 8; v++) begin
            for (int i = 0; i < 16; i++) begin
                if (v > 0 && i == 0) begin
                    chk("tbl_valid", 32'(out_valid), 32'd1);
                    chk("tbl_count", 32'(out_count), 32'(vecs[v-1].exp_count));
                    chk("tbl_sat",   32'(out_sat),   32'(vecs[v-1].exp_sat));
                    chk("tbl_irq",   32'(irq), 32'(IRQ_ON && (vecs[v-1].exp_count >= 4'd3)));
                end
                if (v > 0 && i == 1) begin
                    chk("tbl_valid_drop", 32'(out_valid), 32'd0);
                    chk("tbl_irq_pulse",  32'(irq),       32'd0);
                end
                w = (v < 8) ? vecs[v].wpat[i] : 1'b0;
                @(negedge clk);
            end
        end
        chk("tbl_drop", 32'(drop_cnt), 32'd0);

        // Saturation on the 40-cycle window: 20 rising edges.
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            if (c == 20) chk("sat_none_yet", 32'(out_valid40), 32'd0);
            if (c == 40) begin
                chk("sat_valid", 32'(out_valid40), 32'd1);
                chk("sat_count", 32'(out_count40), 32'd15);
                chk("sat_flag",  32'(out_sat40),   32'd1);
                chk("sat_irq",   32'(irq40),       32'(IRQ_ON));
            end
            w40 = (c < 40) && (c % 2 == 0);
            @(negedge clk);
        end

        // Backpressure for 4 windows: two retained in order, two dropped.
        do_reset();
        out_ready = 1'b0;
        run_pat(16'h0002, 16);
        run_pat(16'h000A, 16);
        chk("bp_valid32", 32'(out_valid), 32'd1);
        chk("bp_count32", 32'(out_count), 32'd1);
        run_pat(16'h002A, 16);
        chk("bp_drop48",  32'(drop_cnt),  32'd1);
        chk("bp_count48", 32'(out_count), 32'd1);
        run_pat(16'h00AA, 16);
        chk("bp_drop64",  32'(drop_cnt),  32'd2);
        chk("bp_head64",  32'(out_count), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid65", 32'(out_valid), 32'd1);
        chk("bp_second",  32'(out_count), 32'd2);
        @(negedge clk);
        chk("bp_empty",   32'(out_valid), 32'd0);

        // Full FIFO with pop and push in the same record cycle.
        do_reset();
        out_ready = 1'b0;
        run_pat(16'h0002, 16);
        run_pat(16'h000A, 16);
        run_pat(16'h002A, 15);
        out_ready = 1'b1;
        @(negedge clk);
        chk("pp_valid", 32'(out_valid), 32'd1);
        chk("pp_head",  32'(out_count), 32'd2);
        chk("pp_drop",  32'(drop_cnt),  32'd0);
        @(negedge clk);
        chk("pp_new",   32'(out_count), 32'd3);
        chk("pp_vnew",  32'(out_valid), 32'd1);
        @(negedge clk);
        chk("pp_empty", 32'(out_valid), 32'd0);

        // clr mid-window (acc=2) and clr on the wrap cycle.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            if (c == 16) chk("clr_norec",    32'(out_valid), 32'd0);
            if (c == 26) begin
                chk("clr_valid",  32'(out_valid), 32'd1);
                chk("clr_count",  32'(out_count), 32'd1);
            end
            if (c == 42) chk("clr_wrap_norec", 32'(out_valid), 32'd0);
            if (c == 58) begin
                chk("clr_wrap_valid", 32'(out_valid), 32'd1);
                chk("clr_wrap_count", 32'(out_count), 32'd0);
            end
            w   = (c == 2) || (c == 5) || (c == 12) || (c == 28);
            clr = (c == 9) || (c == 41);
            @(negedge clk);
        end
        w = 1'b0;
        clr = 1'b0;

        // Asynchronous reset with a record queued and a nonzero drop count.
        do_reset();
        out_ready = 1'b0;
        run_pat(16'h0002, 16);
        run_pat(16'h0002, 16);
        run_pat(16'h0002, 16);
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_drop",  32'(drop_cnt),  32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_drop",  32'(drop_cnt),  32'd0);
        chk("ar_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        run_pat(16'h0092, 16);
        chk("ar_after_valid", 32'(out_valid), 32'd1);
        chk("ar_after_count", 32'(out_count), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
